edge_notifier: RTL and testbench
================================

# edge_notifier

Parametrised multi-channel event notifier: samples an N_CH-bit synchronous input vector every clock, detects per-channel rising, falling or both edges according to a per-channel mode, and reports each event as a toggle, a one-cycle pulse, a saturating count and a sticky flag. It also captures which channel fired first since the last clear. It sits beside the DUT monitors in the bench and RTL, replacing single-bit posedge-triggered notifier registers with clocked, mode-selectable detection on every bit of the vector.

## Interface
- N_CH, 3, number of input channels (≥1)
- CNT_W, 8, width of each per-channel event counter (≥2)
- ID_W, $clog2(N_CH) (min 1), width of first-event channel index
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- d  input  N_CH  monitored signals, synchronous to clk
- mode  input  2*N_CH  per-channel mode, channel i at [2i+1:2i]
- clr  input  1  synchronous clear of counters, sticky flags, first-event capture
- notifier  output  N_CH  per-channel toggle, inverts on each detected event
- evt  output  N_CH  per-channel one-cycle event pulse
- sticky  output  N_CH  per-channel flag, set by event, cleared by clr
- cnt  output  N_CH*CNT_W  per-channel saturating event count, channel i at [(i+1)*CNT_W-1:i*CNT_W]
- first_vld  output  1  at least one event since reset/clr
- first_id  output  ID_W  lowest-index channel among the first events since reset/clr

## Operation
- Mode encoding: 00 off, 01 rise, 10 fall, 11 both.
- Every clock: d_q <= d for all channels, regardless of mode. Edge i = rise (d[i]&~d_q[i]) or fall (~d[i]&d_q[i]) qualified by mode[i]; mode read in the same cycle as d.
- Priming: a primed flag clears on reset and sets on the first clock after rst_n rises. The cycle that loads the first d_q after reset reports no events.
- On edge i: evt[i] high for that one cycle, notifier[i] inverts, sticky[i] set, cnt[i] increments, saturating at 2^CNT_W-1 (no wrap).
- First capture: when first_vld=0 and any edge occurs, first_vld<=1, first_id<=lowest set index. Held until clr or reset.
- clr=1: cnt<=0, sticky<=0, first_vld<=0, first_id<=0. clr wins over a simultaneous event for cnt, sticky and first capture; evt and notifier still respond to that event.
- Mode change: no state change and no spurious event, because d_q always tracks d.
- Reset values: notifier=0, evt=0, sticky=0, cnt=0, first_vld=0, first_id=0, d_q=0, primed=0. Reset asserted mid-operation clears all of these immediately (async).

## Timing
- All outputs registered. A d change that is stable before clock edge k appears on evt/notifier/sticky/cnt after edge k, so latency is one clock from sampling.
- A pulse on d shorter than one clock period is not guaranteed to be seen. Level held N cycles in "both" mode gives exactly two events: entry and exit.
- Back-to-back toggles on consecutive cycles give consecutive evt pulses and count +1 per cycle.
- Simultaneous edges on several channels are all reported in the same cycle. Each counter is independent.

## Structure
- Package edge_notifier_pkg: mode typedef enum logic [1:0] {MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH}. It also holds a saturating-increment function.
- Sub-module edge_notifier_ch, one per channel via generate: d_q, edge detection, notifier, evt, sticky, cnt. It takes primed and clr as inputs.
- Top level: primed flag, first-event priority encoder, output flattening.

## Test plan
- Reset and priming: N_CH=3, d=3'b111 held through rst_n release, mode all BOTH. Required: no evt on the priming clock, all outputs 0. Then d=3'b000 gives evt=3'b111 for one cycle, notifier=3'b111, each cnt=1.
- Modes: ch0=RISE, ch1=FALL, ch2=OFF; drive each d bit 0→1→0. Required: ch0 evt only on the rise, ch1 only on the fall, ch2 none with cnt[2]=0; notifier=3'b011 at the end.
- First capture and clr: edge on ch2 alone, then ch0. Required: first_id=2, first_vld=1. After clr, simultaneous edges on ch1 and ch2 give first_id=1.
- Saturation: CNT_W=2, five rises on ch0. Required: cnt[0]=3 and notifier[0] toggled five times (=1).
- clr with event: clr and ch0 edge in the same cycle. Required: cnt[0]=0, sticky[0]=0, first_vld=0, evt[0] pulses, notifier[0] inverts.
- Async reset mid-run: assert rst_n=0 between clock edges after counts are nonzero. Required: all outputs 0 immediately, and no event on the priming clock after release.

Source files
------------

// File: rtl/edge_notifier_pkg.sv
// Shared types and helpers for the multi-channel edge notifier.
package edge_notifier_pkg;

  typedef enum logic [1:0] {MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH} mode_e;

  // Counters up to 32 bits share this; the caller passes its own ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/edge_notifier_if.sv
// Monitored inputs, control and event outputs of the edge notifier.
interface edge_notifier_if #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 8,
  parameter int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0]       d;
  logic [2*N_CH-1:0]     mode;
  logic                  clr;
  logic [N_CH-1:0]       notifier;
  logic [N_CH-1:0]       evt;
  logic [N_CH-1:0]       sticky;
  logic [N_CH*CNT_W-1:0] cnt;
  logic                  first_vld;
  logic [ID_W-1:0]       first_id;

  modport master (
    output d, mode, clr,
    input  notifier, evt, sticky, cnt, first_vld, first_id
  );

  modport slave (
    input  d, mode, clr,
    output notifier, evt, sticky, cnt, first_vld, first_id
  );
endinterface

// File: rtl/edge_notifier_ch.sv
// One channel: input history, mode-qualified edge detect, toggle/pulse/sticky/count.
module edge_notifier_ch
  import edge_notifier_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             primed,
  input  logic             clr,
  input  logic             d,
  input  logic [1:0]       mode,
  output logic             notifier,
  output logic             evt,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt,
  output logic             hit
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic d_q, rise, fall, raw;

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

  always_comb begin
    raw = 1'b0;
    case (mode_e'(mode))
      MODE_RISE: raw = rise;
      MODE_FALL: raw = fall;
      MODE_BOTH: raw = rise | fall;
      default:   raw = 1'b0;
    endcase
  end

  // d_q is meaningless until the first post-reset sample, so gate on primed.
  assign hit = raw & primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q      <= 1'b0;
      evt      <= 1'b0;
      notifier <= 1'b0;
      sticky   <= 1'b0;
      cnt      <= '0;
    end else begin
      d_q <= d;
      evt <= hit;
      if (hit) notifier <= ~notifier;
      // clr beats a coincident event for the accumulating state only.
      if (clr) begin
        sticky <= 1'b0;
        cnt    <= '0;
      end else if (hit) begin
        sticky <= 1'b1;
        cnt    <= CNT_W'(sat_inc(32'(cnt), 32'(CNT_MAX)));
      end
    end
  end
endmodule

// File: rtl/edge_notifier.sv
// Top: priming flag, per-channel array, first-event capture, output flattening.
module edge_notifier
  import edge_notifier_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int CNT_W = 8,
  parameter int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input logic         clk,
  input logic         rst_n,
  edge_notifier_if.slave bus
);
  logic                        primed;
  logic [N_CH-1:0]             hit, ntf, evt, stk;
  logic [N_CH-1:0][CNT_W-1:0]  cnt_a;
  logic [ID_W-1:0]             hit_id, first_id;
  logic                        first_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) primed <= 1'b0;
    else        primed <= 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_notifier_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .primed   (primed),
      .clr      (bus.clr),
      .d        (bus.d[i]),
      .mode     (bus.mode[2*i +: 2]),
      .notifier (ntf[i]),
      .evt      (evt[i]),
      .sticky   (stk[i]),
      .cnt      (cnt_a[i]),
      .hit      (hit[i])
    );
  end

  // Scan downward so the lowest firing index is the one left standing.
  always_comb begin
    hit_id = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (hit[i]) hit_id = ID_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_vld <= 1'b0;
      first_id  <= '0;
    end else if (bus.clr) begin
      first_vld <= 1'b0;
      first_id  <= '0;
    end else if (!first_vld && |hit) begin
      first_vld <= 1'b1;
      first_id  <= hit_id;
    end
  end

  assign bus.notifier  = ntf;
  assign bus.evt       = evt;
  assign bus.sticky    = stk;
  assign bus.cnt       = cnt_a;
  assign bus.first_vld = first_vld;
  assign bus.first_id  = first_id;
endmodule

// File: tb/tb_edge_notifier.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor checks them.
module tb_edge_notifier;
  localparam int N_CH  = 3;
  localparam int CNT_W = 2;

  typedef struct {
    string      name;
    logic [2:0] nt;
    logic [2:0] ev;
    logic [2:0] st;
    logic [5:0] cn;
    logic       fv;
    logic [1:0] id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;

  edge_notifier_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  edge_notifier #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string n, input string f, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got=%0h want=%0h", n, f, act, exp);
    end
  endfunction

  // Monitor: outputs are registered, so look 1 time unit after each edge (or async reset).
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk or negedge rst_n);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, "notifier",  8'(bus.notifier),  8'(e.nt));
        check(e.name, "evt",       8'(bus.evt),       8'(e.ev));
        check(e.name, "sticky",    8'(bus.sticky),    8'(e.st));
        check(e.name, "cnt",       8'(bus.cnt),       8'(e.cn));
        check(e.name, "first_vld", 8'(bus.first_vld), 8'(e.fv));
        check(e.name, "first_id",  8'(bus.first_id),  8'(e.id));
      end
    end
  end

  function automatic exp_t mk(input string n, input logic [2:0] nt, input logic [2:0] ev,
                              input logic [2:0] st, input logic [5:0] cn, input logic fv,
                              input logic [1:0] id);
    exp_t e;
    e.name = n; e.nt = nt; e.ev = ev; e.st = st; e.cn = cn; e.fv = fv; e.id = id;
    return e;
  endfunction

  // Drive inputs at the falling edge; expectation is for the state after the next rising edge.
  task automatic step(input string n, input logic [2:0] dv, input logic [5:0] mv, input logic c,
                      input logic [2:0] nt, input logic [2:0] ev, input logic [2:0] st,
                      input logic [5:0] cn, input logic fv, input logic [1:0] id);
    @(negedge clk);
    bus.d = dv; bus.mode = mv; bus.clr = c;
    sb.push_back(mk(n, nt, ev, st, cn, fv, id));
  endtask

  localparam logic [5:0] M_BOTH = 6'b111111;
  localparam logic [5:0] M_MIX  = 6'b001001;  // ch0 rise, ch1 fall, ch2 off
  localparam logic [5:0] M_R0   = 6'b000001;  // ch0 rise only
  localparam logic [5:0] M_B0   = 6'b000011;  // ch0 both only

  initial begin
    bus.d = 3'b111; bus.mode = M_BOTH; bus.clr = 1'b0;

    // reset held, then priming clock with d already high: no events
    step("reset",  3'b111, M_BOTH, 0, 3'b000, 3'b000, 3'b000, 6'b000000, 0, 2'd0);
    step("prime",  3'b111, M_BOTH, 0, 3'b000, 3'b000, 3'b000, 6'b000000, 0, 2'd0);
    rst_n = 1'b1;
    step("allfall", 3'b000, M_BOTH, 0, 3'b111, 3'b111, 3'b111, 6'b010101, 1, 2'd0);
    step("hold",    3'b000, M_BOTH, 0, 3'b111, 3'b000, 3'b111, 6'b010101, 1, 2'd0);

    // async reset between edges clears everything at once
    @(negedge clk);
    #2;
    sb.push_back(mk("async_rst", 3'b000, 3'b000, 3'b000, 6'b000000, 0, 2'd0));
    rst_n = 1'b0;
    step("in_rst", 3'b000, M_BOTH, 0, 3'b000, 3'b000, 3'b000, 6'b000000, 0, 2'd0);
    step("prime2", 3'b101, M_BOTH, 0, 3'b000, 3'b000, 3'b000, 6'b000000, 0, 2'd0);
    rst_n = 1'b1;
    step("steady", 3'b101, M_BOTH, 0, 3'b000, 3'b000, 3'b000, 6'b000000, 0, 2'd0);

    // per-channel modes
    step("m_low",  3'b000, M_MIX, 0, 3'b000, 3'b000, 3'b000, 6'b000000, 0, 2'd0);
    step("m_rise", 3'b111, M_MIX, 0, 3'b001, 3'b001, 3'b001, 6'b000001, 1, 2'd0);
    step("m_fall", 3'b000, M_MIX, 0, 3'b011, 3'b010, 3'b011, 6'b000101, 1, 2'd0);

    // first-event capture and clear
    step("clr1",    3'b000, M_BOTH, 1, 3'b011, 3'b000, 3'b000, 6'b000000, 0, 2'd0);
    step("first2",  3'b100, M_BOTH, 0, 3'b111, 3'b100, 3'b100, 6'b010000, 1, 2'd2);
    step("then0",   3'b101, M_BOTH, 0, 3'b110, 3'b001, 3'b101, 6'b010001, 1, 2'd2);
    step("clr2",    3'b101, M_BOTH, 1, 3'b110, 3'b000, 3'b000, 6'b000000, 0, 2'd0);
    step("simul12", 3'b011, M_BOTH, 0, 3'b000, 3'b110, 3'b110, 6'b010100, 1, 2'd1);

    // five rises on ch0: count saturates at 3, toggle ends at 1
    step("f1", 3'b010, M_R0, 0, 3'b000, 3'b000, 3'b110, 6'b010100, 1, 2'd1);
    step("r1", 3'b011, M_R0, 0, 3'b001, 3'b001, 3'b111, 6'b010101, 1, 2'd1);
    step("f2", 3'b010, M_R0, 0, 3'b001, 3'b000, 3'b111, 6'b010101, 1, 2'd1);
    step("r2", 3'b011, M_R0, 0, 3'b000, 3'b001, 3'b111, 6'b010110, 1, 2'd1);
    step("f3", 3'b010, M_R0, 0, 3'b000, 3'b000, 3'b111, 6'b010110, 1, 2'd1);
    step("r3", 3'b011, M_R0, 0, 3'b001, 3'b001, 3'b111, 6'b010111, 1, 2'd1);
    step("f4", 3'b010, M_R0, 0, 3'b001, 3'b000, 3'b111, 6'b010111, 1, 2'd1);
    step("r4", 3'b011, M_R0, 0, 3'b000, 3'b001, 3'b111, 6'b010111, 1, 2'd1);
    step("f5", 3'b010, M_R0, 0, 3'b000, 3'b000, 3'b111, 6'b010111, 1, 2'd1);
    step("r5", 3'b011, M_R0, 0, 3'b001, 3'b001, 3'b111, 6'b010111, 1, 2'd1);

    // clr coincident with an event: pulse and toggle still happen
    step("clr_evt", 3'b010, M_B0, 1, 3'b000, 3'b001, 3'b000, 6'b000000, 0, 2'd0);
    step("after",   3'b010, M_B0, 0, 3'b000, 3'b000, 3'b000, 6'b000000, 0, 2'd0);

    repeat (4) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout reached t=%0t want=finish", $time);
    $fatal(1, "timeout");
  end
endmodule
